// File: rtl/fp32_add_sequencer.sv
// fp32_add_sequencer
// Sequences single FP32 add/subtract operations onto an external adder and
// queues the results, in order, in a small response FIFO.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   req_valid/req_ready      request handshake
//   req_a, req_b             FP32 operands
//   req_sel                  0 = add, 1 = subtract
//   req_rm                   rounding mode (passed through to the adder)
//   req_tag                  caller ID, returned with the response
//   add_ena                  one-cycle start pulse to the adder
//   add_a, add_b             adder operands, held until the next accept
//   add_sel, add_rm          adder select and rounding mode
//   add_s, add_valid         adder result and valid (pulse or level)
//   rsp_valid/rsp_ready      response handshake (FIFO head)
//   rsp_s, rsp_tag           result and tag at the FIFO head
//   rsp_timeout              head entry was produced by a timeout
//   op_count                 completed operations (wrapping)
//   timeout_count            timed-out operations (saturating)
module fp32_add_sequencer #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int RSP_DEPTH      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        req_sel,
    input  logic [1:0]  req_rm,
    input  logic [3:0]  req_tag,
    output logic        add_ena,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    output logic        add_sel,
    output logic [1:0]  add_rm,
    input  logic [31:0] add_s,
    input  logic        add_valid,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_s,
    output logic [3:0]  rsp_tag,
    output logic        rsp_timeout,
    output logic [15:0] op_count,
    output logic [7:0]  timeout_count
);

    localparam int PTR_W  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_W  = $clog2(RSP_DEPTH) + 1;
    localparam int WCNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(RSP_DEPTH);
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]       QNAN_C    = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [31:0]       fifo_s_r   [RSP_DEPTH];
    logic [3:0]        fifo_tag_r [RSP_DEPTH];
    logic              fifo_to_r  [RSP_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic [WCNT_W-1:0] wait_cnt_r;
    logic              prev_add_valid_r;
    logic [3:0]        tag_r;
    logic              add_ena_r;
    logic [31:0]       add_a_r;
    logic [31:0]       add_b_r;
    logic              add_sel_r;
    logic [1:0]        add_rm_r;
    logic [15:0]       op_count_r;
    logic [7:0]        timeout_count_r;

    logic              req_ready_s;
    logic              accept_s;
    logic              completion_s;
    logic              push_s;
    logic              push_to_s;
    logic [31:0]       push_data_s;
    logic              pop_s;

    // Handshake qualifiers; rst masks req_ready so nothing is accepted during reset.
    always_comb begin
        req_ready_s  = (!rst) && (state_r == ST_IDLE) && (count_r < DEPTH_C);
        accept_s     = req_valid && req_ready_s;
        // A level still held from an earlier operation is not a new result.
        completion_s = add_valid && !prev_add_valid_r;
        pop_s        = (count_r != {CNT_W{1'b0}}) && rsp_ready;
    end

    // Next-state logic and FIFO push decision; completion has priority over timeout.
    always_comb begin
        state_nxt_s = state_r;
        push_s      = 1'b0;
        push_to_s   = 1'b0;
        push_data_s = add_s;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_nxt_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (completion_s) begin
                    push_s      = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else if (wait_cnt_r == WAIT_LAST) begin
                    push_s      = 1'b1;
                    push_to_s   = 1'b1;
                    push_data_s = QNAN_C;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, adder interface registers, edge detector and wait counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r          <= ST_IDLE;
            prev_add_valid_r <= 1'b0;
            wait_cnt_r       <= {WCNT_W{1'b0}};
            tag_r            <= 4'h0;
            add_ena_r        <= 1'b0;
            add_a_r          <= 32'h0000_0000;
            add_b_r          <= 32'h0000_0000;
            add_sel_r        <= 1'b0;
            add_rm_r         <= 2'b00;
        end else begin
            state_r          <= state_nxt_s;
            prev_add_valid_r <= add_valid;
            add_ena_r        <= accept_s;
            if (accept_s) begin
                add_a_r   <= req_a;
                add_b_r   <= req_b;
                add_sel_r <= req_sel;
                add_rm_r  <= req_rm;
                tag_r     <= req_tag;
            end
            // Cleared while in ISSUE so it starts at zero on the first WAIT cycle.
            if (state_r == ST_ISSUE) begin
                wait_cnt_r <= {WCNT_W{1'b0}};
            end else if ((state_r == ST_WAIT) && !push_s) begin
                wait_cnt_r <= wait_cnt_r + WCNT_W'(1);
            end
        end
    end

    // Response FIFO storage, pointers, occupancy and operation counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RSP_DEPTH; i++) begin
                fifo_s_r[i]   <= 32'h0000_0000;
                fifo_tag_r[i] <= 4'h0;
                fifo_to_r[i]  <= 1'b0;
            end
            wr_ptr_r        <= {PTR_W{1'b0}};
            rd_ptr_r        <= {PTR_W{1'b0}};
            count_r         <= {CNT_W{1'b0}};
            op_count_r      <= 16'h0000;
            timeout_count_r <= 8'h00;
        end else begin
            if (push_s) begin
                fifo_s_r[wr_ptr_r]   <= push_data_s;
                fifo_tag_r[wr_ptr_r] <= tag_r;
                fifo_to_r[wr_ptr_r]  <= push_to_s;
                wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
                op_count_r           <= op_count_r + 16'h0001;
                if (push_to_s && (timeout_count_r != 8'hFF)) begin
                    timeout_count_r <= timeout_count_r + 8'h01;
                end
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign req_ready     = req_ready_s;
    assign add_ena       = add_ena_r;
    assign add_a         = add_a_r;
    assign add_b         = add_b_r;
    assign add_sel       = add_sel_r;
    assign add_rm        = add_rm_r;
    assign rsp_valid     = (count_r != {CNT_W{1'b0}});
    assign rsp_s         = fifo_s_r[rd_ptr_r];
    assign rsp_tag       = fifo_tag_r[rd_ptr_r];
    assign rsp_timeout   = fifo_to_r[rd_ptr_r];
    assign op_count      = op_count_r;
    assign timeout_count = timeout_count_r;

endmodule

// File: tb/tb_fp32_add_sequencer.sv
`timescale 1ns/1ps
module tb_fp32_add_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        req_sel;
    logic [1:0]  req_rm;
    logic [3:0]  req_tag;
    logic        add_ena;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic        add_sel;
    logic [1:0]  add_rm;
    logic [31:0] add_s;
    logic        add_valid;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_s;
    logic [3:0]  rsp_tag;
    logic        rsp_timeout;
    logic [15:0] op_count;
    logic [7:0]  timeout_count;

    always #5 clk = ~clk;

    fp32_add_sequencer #(.TIMEOUT_CYCLES(64), .RSP_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sel(req_sel), .req_rm(req_rm), .req_tag(req_tag),
        .add_ena(add_ena), .add_a(add_a), .add_b(add_b), .add_sel(add_sel), .add_rm(add_rm),
        .add_s(add_s), .add_valid(add_valid),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_s(rsp_s), .rsp_tag(rsp_tag), .rsp_timeout(rsp_timeout),
        .op_count(op_count), .timeout_count(timeout_count)
    );

    int checks = 0;
    int errors = 0;

    // Expected responses {s[31:0], tag[3:0], timeout}
    logic [36:0] exp_q[$];
    int exp_ops = 0;
    int exp_tos = 0;

    // Adder model configuration for the operation being issued
    logic [31:0] mdl_a, mdl_b, mdl_res;
    logic        mdl_sel;
    logic [1:0]  mdl_rm;
    int          mdl_dly;
    int          mdl_mode;   // 0 pulse, 1 raise and hold, 2 never respond
    int          rdy_mode;   // 0 stall, 1 always ready, 2 random

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: pops one expectation per accepted response
    initial begin
        logic [36:0] e;
        forever begin
            @(negedge clk);
            if (!rst && rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got s=%h tag=%h expected no response", rsp_s, rsp_tag);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_s", rsp_s, e[36:5]);
                    chk("rsp_tag", 32'(rsp_tag), 32'(e[4:1]));
                    chk("rsp_timeout", 32'(rsp_timeout), 32'(e[0]));
                end
            end
        end
    end

    // Adder model: checks operands at the start pulse, answers after mdl_dly cycles
    initial begin
        int          cd = 0;
        int          cur_mode = 0;
        logic [31:0] cur_res = 32'h0;
        logic        prev_ena = 1'b0;
        forever begin
            @(negedge clk);
            if (add_ena && !rst) begin
                chk("add_ena_single", 32'(prev_ena), 32'd0);
                chk("add_a", add_a, mdl_a);
                chk("add_b", add_b, mdl_b);
                chk("add_sel", 32'(add_sel), 32'(mdl_sel));
                chk("add_rm", 32'(add_rm), 32'(mdl_rm));
                if (mdl_mode != 2) begin
                    add_valid = 1'b0;
                    cd        = mdl_dly;
                    cur_res   = mdl_res;
                    cur_mode  = mdl_mode;
                end
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    add_s     = cur_res;
                    add_valid = 1'b1;
                end
            end else if (add_valid && cur_mode == 0) begin
                add_valid = 1'b0;
            end
            prev_ena = add_ena;
        end
    end

    // Response-side ready driver
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 2) rsp_ready = 1'($urandom_range(0, 1));
            else               rsp_ready = (rdy_mode == 1);
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sel,
                         input logic [1:0] rm, input logic [3:0] tag, input logic [31:0] res,
                         input int dly, input int mode, input bit exp_to, input bit push_exp);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL req_ready_wait: got 0 expected 1 within 300 cycles");
        end
        mdl_a = a; mdl_b = b; mdl_sel = sel; mdl_rm = rm;
        mdl_res = res; mdl_dly = dly; mdl_mode = mode;
        if (push_exp) begin
            exp_q.push_back({exp_to ? 32'h7FC0_0000 : res, tag, exp_to});
            exp_ops++;
            if (exp_to) exp_tos++;
        end
        req_valid = 1'b1; req_a = a; req_b = b; req_sel = sel; req_rm = rm; req_tag = tag;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
    endtask

    task automatic wait_ena();
        int n = 0;
        @(negedge clk);
        while (!add_ena && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("add_ena_seen", 32'(add_ena), 32'd1);
    endtask

    initial begin
        int k;
        rst = 1'b1; req_valid = 1'b0; req_a = 32'h0; req_b = 32'h0; req_sel = 1'b0;
        req_rm = 2'b00; req_tag = 4'h0; add_s = 32'h0; add_valid = 1'b0;
        rsp_ready = 1'b1; rdy_mode = 1;
        mdl_a = 32'h0; mdl_b = 32'h0; mdl_sel = 1'b0; mdl_rm = 2'b00;
        mdl_res = 32'h0; mdl_dly = 1; mdl_mode = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_add_ena", 32'(add_ena), 32'd0);
        chk("rst_add_a", add_a, 32'h0);
        chk("rst_rsp_s", rsp_s, 32'h0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        chk("rst_timeout_count", 32'(timeout_count), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(req_ready), 32'd1);

        // Add and subtract
        issue(32'h4000_0000, 32'h4040_0000, 1'b0, 2'b00, 4'd3, 32'h40A0_0000, 3, 0, 1'b0, 1'b1);
        drain();
        chk("op_count_first", 32'(op_count), 32'd1);
        issue(32'h40B0_0000, 32'h3FC0_0000, 1'b1, 2'b01, 4'd5, 32'h4080_0000, 3, 0, 1'b0, 1'b1);
        drain();

        // Timeout with exact latency
        issue(32'h1111_1111, 32'h2222_2222, 1'b0, 2'b10, 4'd7, 32'h0, 1, 2, 1'b1, 1'b1);
        wait_ena();
        k = 0;
        while (!rsp_valid && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("timeout_latency", 32'(k), 32'd65);
        chk("ready_after_timeout", 32'(req_ready), 32'd1);
        drain();
        chk("timeout_count_1", 32'(timeout_count), 32'd1);

        // Result on the last WAIT cycle wins; one cycle later is a timeout
        issue(32'h3F80_0000, 32'h3F80_0000, 1'b0, 2'b00, 4'd9, 32'h4000_0000, 64, 0, 1'b0, 1'b1);
        drain();
        issue(32'h3F80_0000, 32'h4000_0000, 1'b0, 2'b00, 4'd10, 32'h4040_0000, 65, 0, 1'b1, 1'b1);
        drain();
        repeat (5) @(negedge clk);

        // Held add_valid: second op times out, third needs a fresh rising edge
        issue(32'hAAAA_0000, 32'h0000_5555, 1'b0, 2'b00, 4'd1, 32'h1234_5678, 2, 1, 1'b0, 1'b1);
        drain();
        issue(32'hBBBB_0000, 32'h0000_6666, 1'b1, 2'b11, 4'd2, 32'h0, 1, 2, 1'b1, 1'b1);
        drain();
        issue(32'hCCCC_0000, 32'h0000_7777, 1'b0, 2'b01, 4'd4, 32'h8765_4321, 2, 0, 1'b0, 1'b1);
        drain();

        // Back-pressure: fill the FIFO, then release in order
        rdy_mode = 0;
        for (int t = 0; t < 4; t++) begin
            issue(32'(t) + 32'h4100_0000, 32'h4200_0000, 1'b0, 2'b00, 4'(t),
                  32'hC000_0000 + 32'(t), 2, 0, 1'b0, 1'b1);
        end
        repeat (8) @(negedge clk);
        chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("bp_req_ready", 32'(req_ready), 32'd0);
        rdy_mode = 1;
        drain();
        chk("bp_ready_after_drain", 32'(req_ready), 32'd1);

        // Randomized traffic with random back-pressure
        rdy_mode = 2;
        for (int t = 0; t < 24; t++) begin
            issue($urandom, $urandom, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  4'($urandom_range(0, 15)), $urandom, $urandom_range(1, 12), 0, 1'b0, 1'b1);
        end
        drain();
        rdy_mode = 1;
        repeat (2) @(negedge clk);
        chk("op_count_total", 32'(op_count), 32'(exp_ops));
        chk("timeout_count_total", 32'(timeout_count), 32'(exp_tos));

        // Reset during WAIT discards the operation
        issue(32'h5555_5555, 32'h6666_6666, 1'b0, 2'b00, 4'd12, 32'hDEAD_BEEF, 8, 0, 1'b0, 1'b0);
        wait_ena();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_ops = 0;
        exp_tos = 0;
        repeat (15) @(negedge clk);
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_op_count", 32'(op_count), 32'(exp_ops));
        chk("midrst_req_ready", 32'(req_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
